// File: rtl/sd_pkg.sv
// Shared types and the default SD SPI-mode init command table for the init sequencer.
package sd_pkg;

  typedef struct packed {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic [7:0]  nresp;
    logic [7:0]  mask;
    logic [7:0]  exp_r1;
    logic        retry_en;
  } step_t;

  localparam logic [7:0] R1_IDLE  = 8'h01;
  localparam logic [7:0] R1_READY = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_WAIT,
    ST_CHECK,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  // CMD0 reset, CMD8 interface condition (R7), then CMD55/ACMD41 polled until the card leaves idle.
  function automatic step_t sd_step_entry(input int unsigned idx);
    step_t e;
    e = '0;
    case (idx)
      0: e = '{cmd: 6'd0,  arg: 32'h0000_0000, crc: 7'h4A, nresp: 8'd1,
               mask: 8'hFF, exp_r1: R1_IDLE,  retry_en: 1'b0};
      1: e = '{cmd: 6'd8,  arg: 32'h0000_01AA, crc: 7'h43, nresp: 8'd5,
               mask: 8'hFF, exp_r1: R1_IDLE,  retry_en: 1'b0};
      2: e = '{cmd: 6'd55, arg: 32'h0000_0000, crc: 7'h32, nresp: 8'd1,
               mask: 8'hFF, exp_r1: R1_IDLE,  retry_en: 1'b1};
      3: e = '{cmd: 6'd41, arg: 32'h4000_0000, crc: 7'h3B, nresp: 8'd1,
               mask: 8'hFF, exp_r1: R1_READY, retry_en: 1'b1};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sd_seq_timer.sv
// Down-counting interval timer shared by the SETUP, WAIT and GAP phases.
module sd_seq_timer #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/sd_init_sequencer.sv
// Steps through the SD command table, captures responses, retries or aborts per entry.
module sd_init_sequencer
  import sd_pkg::*;
#(
  parameter int unsigned NUM_STEPS      = 4,
  parameter int unsigned RESP_BYTES     = 5,
  parameter int unsigned MAX_RETRIES    = 255,
  parameter int unsigned TIMEOUT_CYCLES = 4095,
  parameter int unsigned SETUP_CYCLES   = 5,
  parameter int unsigned GAP_CYCLES     = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              go,
  output logic [5:0]                        sd_cmd,
  output logic [31:0]                       sd_arg,
  output logic [6:0]                        sd_crc,
  output logic [$clog2(RESP_BYTES+1)-1:0]   sd_nresp,
  output logic                              sd_start,
  input  logic                              sd_done,
  input  logic                              rx_valid,
  input  logic [7:0]                        rx_data,
  output logic                              ss,
  output logic                              busy,
  output logic                              init_done,
  output logic                              error,
  output logic [$clog2(NUM_STEPS)-1:0]      err_step,
  output logic [7:0]                        last_r1,
  output logic [8*RESP_BYTES-1:0]           resp,
  output logic [5:0]                        status_led
);

  localparam int unsigned RW   = $clog2(RESP_BYTES + 1);
  localparam int unsigned SW   = $clog2(NUM_STEPS);
  localparam int unsigned CW   = $clog2(MAX_RETRIES + 1);
  localparam int unsigned TMAX = (TIMEOUT_CYCLES > SETUP_CYCLES)
                               ? ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES)
                               : ((SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);
  localparam logic [RW-1:0] RESP_MAX  = RW'(RESP_BYTES);
  localparam logic [CW-1:0] RETRY_MAX = CW'(MAX_RETRIES);

  seq_state_t                state_q, state_d;
  logic [SW-1:0]             step_q, step_d;
  logic [SW-1:0]             err_step_q, err_step_d;
  logic [CW-1:0]             retries_q, retries_d;
  logic [RW-1:0]             byte_cnt_q, byte_cnt_d;
  logic [8*RESP_BYTES-1:0]   resp_q, resp_d;
  logic [7:0]                last_r1_q, last_r1_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_expired;
  logic          do_fail;
  logic          pass_chk;
  logic          can_retry;
  logic          in_cmd;
  step_t         cur;

  sd_seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  assign cur       = sd_step_entry(32'(step_q));
  assign pass_chk  = (cur.nresp == 8'd0) || ((last_r1_q & cur.mask) == cur.exp_r1);
  assign can_retry = cur.retry_en && (retries_q < RETRY_MAX);
  assign in_cmd    = (state_q == ST_SETUP) || (state_q == ST_START) ||
                     (state_q == ST_WAIT)  || (state_q == ST_CHECK);

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    err_step_d = err_step_q;
    retries_d  = retries_q;
    byte_cnt_d = byte_cnt_q;
    resp_d     = resp_q;
    last_r1_d  = last_r1_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    do_fail    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (go) begin
          step_d     = '0;
          retries_d  = '0;
          byte_cnt_d = '0;
          resp_d     = '0;
          last_r1_d  = 8'hFF;
          tmr_load   = 1'b1;
          tmr_val    = TW'(SETUP_CYCLES - 1);
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_expired) state_d = ST_START;
      end
      ST_START: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(TIMEOUT_CYCLES - 1);
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (rx_valid && (byte_cnt_q < RESP_MAX)) begin
          for (int unsigned i = 0; i < RESP_BYTES; i++) begin
            if (byte_cnt_q == RW'(i)) resp_d[i*8 +: 8] = rx_data;
          end
          if (byte_cnt_q == '0) last_r1_d = rx_data;
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
        if (sd_done) begin
          state_d = ST_CHECK;
        end else if (tmr_expired) begin
          do_fail = 1'b1;
        end
      end
      ST_CHECK: begin
        if (pass_chk) begin
          if (step_q == LAST_STEP) begin
            state_d = ST_DONE;
          end else begin
            step_d     = step_q + 1'b1;
            retries_d  = '0;
            byte_cnt_d = '0;
            tmr_load   = 1'b1;
            tmr_val    = TW'(GAP_CYCLES - 1);
            state_d    = ST_GAP;
          end
        end else begin
          do_fail = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(SETUP_CYCLES - 1);
          state_d  = ST_SETUP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // WAIT timeout and CHECK mismatch share one retry/abort decision, taken straight from either state.
    if (do_fail) begin
      if (can_retry) begin
        retries_d  = retries_q + 1'b1;
        byte_cnt_d = '0;
        tmr_load   = 1'b1;
        tmr_val    = TW'(GAP_CYCLES - 1);
        state_d    = ST_GAP;
      end else begin
        err_step_d = step_q;
        state_d    = ST_ERROR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      err_step_q <= '0;
      retries_q  <= '0;
      byte_cnt_q <= '0;
      resp_q     <= '0;
      last_r1_q  <= 8'hFF;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      err_step_q <= err_step_d;
      retries_q  <= retries_d;
      byte_cnt_q <= byte_cnt_d;
      resp_q     <= resp_d;
      last_r1_q  <= last_r1_d;
    end
  end

  assign sd_cmd     = in_cmd ? cur.cmd : '0;
  assign sd_arg     = in_cmd ? cur.arg : '0;
  assign sd_crc     = in_cmd ? cur.crc : '0;
  assign sd_nresp   = in_cmd ? RW'(cur.nresp) : '0;
  assign sd_start   = (state_q == ST_START);
  assign ss         = !in_cmd;
  assign busy       = in_cmd || (state_q == ST_GAP);
  assign init_done  = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign err_step   = err_step_q;
  assign last_r1    = last_r1_q;
  assign resp       = resp_q;
  assign status_led = {error, init_done, busy, 3'(step_q)};

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench: acts as the SD controller, replaying a table of command transactions.
module tb_sd_init_sequencer;

  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        rst_n, go, sd_done, rx_valid;
  logic [7:0]  rx_data;
  logic [5:0]  sd_cmd;
  logic [31:0] sd_arg;
  logic [6:0]  sd_crc;
  logic [2:0]  sd_nresp;
  logic        sd_start, ss, busy, init_done, error;
  logic [1:0]  err_step;
  logic [7:0]  last_r1;
  logic [39:0] resp;
  logic [5:0]  status_led;

  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;
  int acmd_cnt = 0;

  sd_init_sequencer #(
    .NUM_STEPS      (4),
    .RESP_BYTES     (5),
    .MAX_RETRIES    (255),
    .TIMEOUT_CYCLES (TO),
    .SETUP_CYCLES   (5),
    .GAP_CYCLES     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .sd_cmd     (sd_cmd),
    .sd_arg     (sd_arg),
    .sd_crc     (sd_crc),
    .sd_nresp   (sd_nresp),
    .sd_start   (sd_start),
    .sd_done    (sd_done),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .ss         (ss),
    .busy       (busy),
    .init_done  (init_done),
    .error      (error),
    .err_step   (err_step),
    .last_r1    (last_r1),
    .resp       (resp),
    .status_led (status_led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sd_start) begin
      start_cnt++;
      if (sd_cmd == 6'd41) acmd_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic [2:0]  nresp;
    int          gap;
    int          n_rx;
    logic [55:0] rx;
    logic        send_done;
  } txn_t;

  txn_t tbl [0:6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!sd_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", 64'(sd_start), 64'd1);
  endtask

  // Returns at the negedge where the sequencer sits in CHECK for this command.
  task automatic do_cmd(input txn_t t);
    int lo = 0;
    int hi = 0;
    int n = 0;
    logic [55:0] bytes;
    while (!sd_start && n < 200) begin
      if (ss) begin
        hi++;
        lo = 0;
      end else begin
        lo++;
      end
      n++;
      @(negedge clk);
    end
    chk("start_seen", 64'(sd_start), 64'd1);
    if (!sd_start) return;
    chk("setup_len", 64'(lo), 64'd5);
    chk("gap_len", 64'(hi), 64'(t.gap));
    chk("sd_cmd", 64'(sd_cmd), 64'(t.cmd));
    chk("sd_arg", 64'(sd_arg), 64'(t.arg));
    chk("sd_crc", 64'(sd_crc), 64'(t.crc));
    chk("sd_nresp", 64'(sd_nresp), 64'(t.nresp));
    @(negedge clk);
    chk("start_pulse", 64'(sd_start), 64'd0);
    bytes = t.rx;
    for (int i = 0; i < t.n_rx; i++) begin
      rx_valid = 1'b1;
      rx_data  = bytes[i*8 +: 8];
      sd_done  = t.send_done && (i == t.n_rx - 1);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    sd_done  = 1'b0;
  endtask

  task automatic run_go();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("go_busy", 64'(busy), 64'd1);
    chk("go_clr_done", 64'(init_done), 64'd0);
    chk("go_clr_err", 64'(error), 64'd0);
  endtask

  initial begin
    tbl[0] = '{6'd0,  32'h0000_0000, 7'h4A, 3'd1, 0, 1, 56'h01, 1'b1};
    tbl[1] = '{6'd8,  32'h0000_01AA, 7'h43, 3'd5, 8, 5, 56'h00_00_AA_01_00_00_01, 1'b1};
    tbl[2] = '{6'd55, 32'h0000_0000, 7'h32, 3'd1, 8, 1, 56'h01, 1'b1};
    tbl[3] = '{6'd41, 32'h4000_0000, 7'h3B, 3'd1, 8, 1, 56'h00, 1'b1};
    tbl[4] = '{6'd41, 32'h4000_0000, 7'h3B, 3'd1, 8, 1, 56'h01, 1'b1};
    tbl[5] = '{6'd0,  32'h0000_0000, 7'h4A, 3'd1, 0, 1, 56'hFF, 1'b1};
    tbl[6] = '{6'd8,  32'h0000_01AA, 7'h43, 3'd5, 8, 7, 56'h66_55_AA_01_00_00_01, 1'b1};

    rst_n = 1'b0; go = 1'b0; sd_done = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ss", 64'(ss), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(sd_start), 64'd0);
    chk("rst_done", 64'(init_done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_last_r1", 64'(last_r1), 64'hFF);
    chk("rst_resp", 64'(resp), 64'd0);
    chk("rst_cmd", 64'(sd_cmd), 64'd0);
    chk("rst_led", 64'(status_led), 64'd0);

    // Full pass through all four steps.
    run_go();
    for (int i = 0; i < 4; i++) do_cmd(tbl[i]);
    @(negedge clk);
    chk("a_init_done", 64'(init_done), 64'd1);
    chk("a_error", 64'(error), 64'd0);
    chk("a_ss", 64'(ss), 64'd1);
    chk("a_busy", 64'(busy), 64'd0);
    chk("a_resp", 64'(resp), 64'hAA_01_00_00_00);
    chk("a_last_r1", 64'(last_r1), 64'h00);
    chk("a_led", 64'(status_led), 64'b010011);

    // ACMD41 stays idle three times before reporting ready.
    begin
      int acmd0;
      run_go();
      acmd0 = acmd_cnt;
      for (int i = 0; i < 3; i++) do_cmd(tbl[i]);
      for (int i = 0; i < 3; i++) do_cmd(tbl[4]);
      do_cmd(tbl[3]);
      @(negedge clk);
      chk("b_acmd41_tries", 64'(acmd_cnt - acmd0), 64'd4);
      chk("b_init_done", 64'(init_done), 64'd1);
      chk("b_error", 64'(error), 64'd0);
    end

    // CMD0 answered with FF: abort at step 0, no retry.
    begin
      int s0;
      run_go();
      do_cmd(tbl[5]);
      @(negedge clk);
      chk("c_error", 64'(error), 64'd1);
      chk("c_err_step", 64'(err_step), 64'd0);
      chk("c_ss", 64'(ss), 64'd1);
      chk("c_busy", 64'(busy), 64'd0);
      chk("c_led", 64'(status_led), 64'b100000);
      s0 = start_cnt;
      repeat (20) @(negedge clk);
      chk("c_no_retry", 64'(start_cnt - s0), 64'd0);
    end

    // sd_done withheld: error follows the TO-th WAIT cycle.
    run_go();
    wait_start();
    for (int n = 1; n <= TO; n++) begin
      @(negedge clk);
      if (n == TO) begin
        chk("d_wait_last_err", 64'(error), 64'd0);
        chk("d_wait_last_busy", 64'(busy), 64'd1);
      end
    end
    @(negedge clk);
    chk("d_timeout_err", 64'(error), 64'd1);
    chk("d_err_step", 64'(err_step), 64'd0);

    // CMD8 overrun: 7 bytes into a 5-byte buffer.
    run_go();
    do_cmd(tbl[0]);
    do_cmd(tbl[6]);
    chk("e_resp", 64'(resp), 64'hAA_01_00_00_01);
    chk("e_last_r1", 64'(last_r1), 64'h01);

    // go during WAIT is ignored, then reset lands mid-command.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_go();
    wait_start();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("f_go_busy", 64'(busy), 64'd1);
    rx_valid = 1'b1; rx_data = 8'h01; sd_done = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; sd_done = 1'b0;
    chk("f_go_ignored_r1", 64'(last_r1), 64'h01);
    wait_start();
    chk("f_cmd8", 64'(sd_cmd), 64'd8);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h05;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("f_pre_rst_r1", 64'(last_r1), 64'h05);
    rst_n = 1'b0;
    @(negedge clk);
    chk("f_rst_ss", 64'(ss), 64'd1);
    chk("f_rst_busy", 64'(busy), 64'd0);
    chk("f_rst_start", 64'(sd_start), 64'd0);
    chk("f_rst_r1", 64'(last_r1), 64'hFF);
    chk("f_rst_resp", 64'(resp), 64'd0);
    chk("f_rst_led", 64'(status_led), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_init_sequencer.md
SD_INIT_SEQUENCER -- requirements
Module: sd_init_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- NUM_STEPS, 4, command-table entries executed in order.
- RESP_BYTES, 5, response bytes buffered per step.
- MAX_RETRIES, 255, retries allowed per retryable step.
- TIMEOUT_CYCLES, 4095, clk cycles allowed from start to sd_done.
- SETUP_CYCLES, 5, clk cycles from ss low to sd_start.
- GAP_CYCLES, 8, clk cycles ss high between retries.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst_n, in, 1, synchronous active-low reset.
- go, in, 1, one-cycle request to run the sequence.
- sd_cmd, out, 6, command index to SD controller.
- sd_arg, out, 32, command argument.
- sd_crc, out, 7, command CRC7.
- sd_nresp, out, RW=$clog2(RESP_BYTES+1), expected response byte count.
- sd_start, out, 1, command start strobe.
- sd_done, in, 1, controller command complete.
- rx_valid, in, 1, response byte strobe (SPI write).
- rx_data, in, 8, response byte.
- ss, out, 1, card select, active low.
- busy, out, 1, sequence running.
- init_done, out, 1, all steps passed.
- error, out, 1, sequence aborted.
- err_step, out, SW=$clog2(NUM_STEPS), step that failed.
- last_r1, out, 8, first response byte of current/last step.
- resp, out, 8*RESP_BYTES, response buffer, byte 0 in [7:0].
- status_led, out, 6, {error, init_done, busy, step[2:0]}.

Function
REQ-003 SHALL hold per-step table entries {cmd, arg, crc, nresp, mask, expect, retry_en} read from the shared package.
REQ-004 SHALL implement states IDLE, SETUP, START, WAIT, CHECK, GAP, DONE, ERROR.
REQ-005 IDLE/DONE/ERROR + go SHALL clear step, retries, byte count, resp, last_r1, init_done, error; enter SETUP next cycle.
REQ-006 go while busy SHALL be ignored.
REQ-007 SETUP: ss=0, count SETUP_CYCLES, then START.
REQ-008 START: sd_start=1 for exactly 1 cycle, sd_cmd/arg/crc/nresp driven from current entry throughout SETUP..CHECK; then WAIT.
REQ-009 WAIT: each rx_valid stores rx_data at resp[byte_cnt] while byte_cnt<RESP_BYTES, further bytes dropped; byte 0 also loads last_r1.
REQ-010 WAIT: sd_done -> CHECK; rx_valid coincident with sd_done SHALL be captured before CHECK evaluates.
REQ-011 WAIT: timeout counter reaching TIMEOUT_CYCLES without sd_done SHALL be treated as a failed check.
REQ-012 CHECK: pass when nresp==0 or (last_r1 & mask)==expect; pass on last step -> DONE, else step+1, retries=0, byte_cnt=0, -> GAP.
REQ-013 CHECK fail: retry_en and retries<MAX_RETRIES -> retries+1, byte_cnt=0, -> GAP (same step); otherwise err_step=step -> ERROR.
REQ-014 GAP: ss=1 for GAP_CYCLES, then SETUP.
REQ-015 DONE: ss=1, init_done=1, busy=0. ERROR: ss=1, error=1, busy=0.
REQ-016 busy SHALL be 1 in SETUP, START, WAIT, CHECK, GAP.
REQ-017 Counters SHALL be sized $clog2(max+1), never wrap; retries saturates at MAX_RETRIES.

Reset
REQ-018 rst_n=0 at clk edge SHALL force IDLE, ss=1, sd_start=0, busy=0, init_done=0, error=0, err_step=0, last_r1=8'hFF, resp=0, step/counters=0, sd_cmd/arg/crc/nresp=0.
REQ-019 Reset mid-command SHALL abort with ss=1 and sd_start=0 on the next cycle; no partial state retained.

Structure
REQ-020 Shared package sd_pkg SHALL hold step_t struct, R1 constants (R1_IDLE=8'h01, R1_READY=8'h00), and default table (CMD0 arg 0 crc 7'h4A expect 01; CMD8 arg 32'h1AA crc 7'h43 expect 01; CMD55 expect 01 retry; ACMD41 arg 32'h40000000 expect 00 retry).
REQ-021 One sub-module sd_seq_timer (load/count/expire) SHALL serve SETUP, WAIT and GAP counts.

Verification
REQ-022 Bench SHALL cover:
- go, model returns 01,01/000001AA,01,00 -> init_done=1 after 4 steps, error=0, ss high.
- ACMD41 returns 01 three times then 00 -> three GAP retries, retries=3, init_done=1.
- CMD0 returns 8'hFF -> error=1, err_step=0, no retry.
- sd_done withheld TIMEOUT_CYCLES=100 -> error at cycle 100 of WAIT.
- CMD8 sends 7 bytes, RESP_BYTES=5 -> resp holds first 5 bytes, last_r1=01.
- rst_n low during WAIT -> next cycle ss=1, busy=0, last_r1=FF; go while busy ignored.
